// File: rtl/rv_pkg.sv
// Shared RISC-V core types: writeback source and load size encodings.
// Default datapath and register-file geometry.
package rv_pkg;

  localparam int REG_DATA_WIDTH_POW = 6;
  localparam int REG_MEM_DEPTH_POW  = 5;
  localparam int REG_DATA_WIDTH     = 1 << REG_DATA_WIDTH_POW;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    LS_B = 2'b00,
    LS_H = 2'b01,
    LS_W = 2'b10,
    LS_D = 2'b11
  } load_size_e;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Load data extension: right-aligned raw load data to a full register value.
// Sign- or zero-extends byte/half/word loads; doubleword passes through.
module load_extend
  import rv_pkg::*;
#(
  parameter int DW = REG_DATA_WIDTH
) (
  input  logic [DW-1:0] data_in,
  input  load_size_e    size_in,
  input  logic          unsigned_in,
  output logic [DW-1:0] data_out
);

  logic sb;
  logic sh;
  logic sw;

  assign sb = ~unsigned_in & data_in[7];
  assign sh = ~unsigned_in & data_in[15];
  assign sw = ~unsigned_in & data_in[31];

  always_comb begin
    data_out = data_in;
    unique case (size_in)
      LS_B: data_out = {{(DW-8){sb}}, data_in[7:0]};
      LS_H: data_out = {{(DW-16){sh}}, data_in[15:0]};
      LS_W: data_out = {{(DW-32){sw}}, data_in[31:0]};
      LS_D: data_out = data_in;
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback mux feeding the register file.
// Also provides the EX forwarding tap, a retire counter and a sticky error flag.
module mem_wb_stage
  import rv_pkg::*;
#(
  parameter int REG_DATA_WIDTH_POW = rv_pkg::REG_DATA_WIDTH_POW,
  parameter int REG_MEM_DEPTH_POW  = rv_pkg::REG_MEM_DEPTH_POW,
  parameter int RETIRE_CNT_WIDTH   = 32
) (
  input  logic                           clk_in,
  input  logic                           reset_n,
  input  logic                           valid_in,
  input  logic                           stall_in,
  input  logic                           flush_in,
  input  logic [REG_MEM_DEPTH_POW-1:0]   rd_in,
  input  logic                           reg_write_in,
  input  logic [1:0]                     wb_sel_in,
  input  logic [1:0]                     load_size_in,
  input  logic                           load_unsigned_in,
  input  logic [(1<<REG_DATA_WIDTH_POW)-1:0] alu_result_in,
  input  logic [(1<<REG_DATA_WIDTH_POW)-1:0] load_data_in,
  input  logic [(1<<REG_DATA_WIDTH_POW)-1:0] pc_plus4_in,
  output logic [REG_MEM_DEPTH_POW-1:0]   rd_out,
  output logic [(1<<REG_DATA_WIDTH_POW)-1:0] data_write_out,
  output logic                           write_en_out,
  output logic                           fwd_valid_out,
  output logic [RETIRE_CNT_WIDTH-1:0]    retired_cnt_out,
  output logic                           wb_err_out
);

  localparam int DW = 1 << REG_DATA_WIDTH_POW;

  logic                         take;
  logic [DW-1:0]                ld_ext;
  logic [DW-1:0]                wb_data;
  logic                         rsvd;

  logic                         valid_q;
  logic [REG_MEM_DEPTH_POW-1:0] rd_q;
  logic [DW-1:0]                data_q;
  logic                         reg_write_q;
  logic [RETIRE_CNT_WIDTH-1:0]  cnt_q;
  logic                         err_q;

  assign take = valid_in & ~stall_in & ~flush_in;

  load_extend #(
    .DW(DW)
  ) u_load_extend (
    .data_in    (load_data_in),
    .size_in    (load_size_e'(load_size_in)),
    .unsigned_in(load_unsigned_in),
    .data_out   (ld_ext)
  );

  always_comb begin
    wb_data = '0;
    rsvd    = 1'b0;
    unique case (wb_sel_e'(wb_sel_in))
      WB_ALU:  wb_data = alu_result_in;
      WB_LOAD: wb_data = ld_ext;
      WB_PC4:  wb_data = pc_plus4_in;
      WB_RSVD: rsvd    = 1'b1;
      default: rsvd    = 1'b1;
    endcase
  end

  // Counting on capture keeps the count in step with the instruction
  // currently presented at the write port.
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      rd_q        <= '0;
      data_q      <= '0;
      reg_write_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      valid_q <= take;
      if (take) begin
        rd_q        <= rd_in;
        data_q      <= wb_data;
        reg_write_q <= reg_write_in & ~rsvd;
        cnt_q       <= cnt_q + RETIRE_CNT_WIDTH'(1);
        if (rsvd)
          err_q <= 1'b1;
      end
    end
  end

  assign rd_out          = rd_q;
  assign data_write_out  = data_q;
  assign write_en_out    = valid_q & reg_write_q & (rd_q != '0);
  assign fwd_valid_out   = write_en_out;
  assign retired_cnt_out = cnt_q;
  assign wb_err_out      = err_q;

endmodule
